// File: rtl/board_editor_if.sv
// Bundle of signals between a controller (master) and board_editor (slave).
// Parameters:
//   ROWS, COLS : board size; RW, CW are the derived cursor widths.
// Signals driven by master:
//   select, btn_up/down/left/right/center/clear, mode, cell_inputs, input_board
// Signals driven by slave:
//   board_o, cursor_row, cursor_col, busy, editing
interface board_editor_if #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 16,
  parameter int unsigned RW   = $clog2(ROWS),
  parameter int unsigned CW   = $clog2(COLS)
) ();
  logic                 select;
  logic                 btn_up;
  logic                 btn_down;
  logic                 btn_left;
  logic                 btn_right;
  logic                 btn_center;
  logic                 btn_clear;
  logic                 mode;
  logic [COLS-1:0]      cell_inputs;
  logic [ROWS*COLS-1:0] input_board;
  logic [ROWS*COLS-1:0] board_o;
  logic [RW-1:0]        cursor_row;
  logic [CW-1:0]        cursor_col;
  logic                 busy;
  logic                 editing;

  modport master (
    output select, btn_up, btn_down, btn_left, btn_right, btn_center, btn_clear,
    output mode, cell_inputs, input_board,
    input  board_o, cursor_row, cursor_col, busy, editing
  );

  modport slave (
    input  select, btn_up, btn_down, btn_left, btn_right, btn_center, btn_clear,
    input  mode, cell_inputs, input_board,
    output board_o, cursor_row, cursor_col, busy, editing
  );
endinterface

// File: rtl/board_editor.sv
// Board-entry block for the Game of Life core.
// Captures the engine's live board when select rises, then lets the user edit it
// with a button-driven cursor: whole-row writes from cell_inputs (mode=0), single-cell
// toggles (mode=1), or a row-by-row clear. board_o only feeds the engine's load path.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : board_editor_if slave modport (buttons, select, mode, cell_inputs,
//           input_board in; board_o, cursor_row, cursor_col, busy, editing out)
// Parameters: ROWS, COLS (>= 2), WRAP (0 = saturate, 1 = wrap); RW, CW derived.
module board_editor #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 16,
  parameter int unsigned WRAP = 0,
  parameter int unsigned RW   = $clog2(ROWS),
  parameter int unsigned CW   = $clog2(COLS)
) (
  input logic          clk,
  input logic          reset,
  board_editor_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StEdit  = 2'd2;
  localparam logic [1:0] StClear = 2'd3;

  localparam logic [RW-1:0] RowMax = RW'(ROWS - 1);
  localparam logic [CW-1:0] ColMax = CW'(COLS - 1);

  logic [1:0]                state_q, state_d;
  logic [ROWS-1:0][COLS-1:0] board_q, board_d;
  logic [RW-1:0]             row_q, row_d;
  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             clr_row_q, clr_row_d;

  // Input history for edge detection; sampled every cycle in every state.
  logic sel_q, up_q, down_q, left_q, right_q, center_q, clear_q;

  logic sel_ev, up_ev, down_ev, left_ev, right_ev, center_ev, clear_ev;
  logic [RW-1:0] row_dec, row_inc;
  logic [CW-1:0] col_dec, col_inc;

  assign sel_ev    = bus.select     & ~sel_q;
  assign up_ev     = bus.btn_up     & ~up_q;
  assign down_ev   = bus.btn_down   & ~down_q;
  assign left_ev   = bus.btn_left   & ~left_q;
  assign right_ev  = bus.btn_right  & ~right_q;
  assign center_ev = bus.btn_center & ~center_q;
  assign clear_ev  = bus.btn_clear  & ~clear_q;

  // Edge behaviour: saturate (hold) or wrap to the opposite edge.
  assign row_dec = (row_q == '0)    ? ((WRAP != 0) ? RowMax : row_q) : row_q - 1'b1;
  assign row_inc = (row_q == RowMax) ? ((WRAP != 0) ? '0 : row_q)    : row_q + 1'b1;
  assign col_dec = (col_q == '0)    ? ((WRAP != 0) ? ColMax : col_q) : col_q - 1'b1;
  assign col_inc = (col_q == ColMax) ? ((WRAP != 0) ? '0 : col_q)    : col_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    row_d     = row_q;
    col_d     = col_q;
    clr_row_d = clr_row_q;

    case (state_q)
      StIdle: begin
        if (sel_ev) state_d = StLoad;
      end

      StLoad: begin
        board_d = bus.input_board;
        row_d   = '0;
        col_d   = '0;
        state_d = StEdit;
      end

      StEdit: begin
        // Leaving edit mode wins over any event arriving in the same cycle.
        if (!bus.select) begin
          state_d = StIdle;
        end else if (clear_ev) begin
          state_d   = StClear;
          clr_row_d = '0;
        end else if (center_ev) begin
          if (!bus.mode) begin
            board_d[row_q] = bus.cell_inputs;
          end else begin
            board_d[row_q][col_q] = ~board_q[row_q][col_q];
          end
        end else begin
          // Opposite presses in the same cycle cancel.
          if (up_ev && !down_ev) row_d = row_dec;
          else if (down_ev && !up_ev) row_d = row_inc;
          if (left_ev && !right_ev) col_d = col_dec;
          else if (right_ev && !left_ev) col_d = col_inc;
        end
      end

      StClear: begin
        board_d[clr_row_q] = '0;
        // Runs to completion regardless of select; select decides where to land.
        if (clr_row_q == RowMax) begin
          state_d = bus.select ? StEdit : StIdle;
        end else begin
          clr_row_d = clr_row_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      board_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      clr_row_q <= '0;
      sel_q     <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      center_q  <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      row_q     <= row_d;
      col_q     <= col_d;
      clr_row_q <= clr_row_d;
      sel_q     <= bus.select;
      up_q      <= bus.btn_up;
      down_q    <= bus.btn_down;
      left_q    <= bus.btn_left;
      right_q   <= bus.btn_right;
      center_q  <= bus.btn_center;
      clear_q   <= bus.btn_clear;
    end
  end

  assign bus.board_o    = board_q;
  assign bus.cursor_row = row_q;
  assign bus.cursor_col = col_q;
  assign bus.busy       = (state_q == StClear);
  assign bus.editing    = (state_q == StEdit);

endmodule

// File: doc/board_editor.md
Name: board_editor

Overview:
- Parametrised board-entry block for the Game of Life core.
- When select is asserted, it captures the current simulation board and lets the user edit it with a row/column cursor driven by buttons.
- Edits are either whole-row writes from the switches or single-cell toggles; a sequenced clear is also available.
- board_o feeds the simulation engine's load path; the block drives only board_o and status, never the engine itself.

Parameters:
ROWS, 16, board height in rows (>= 2)
COLS, 16, board width in columns (>= 2)
WRAP, 0, 0 = cursor saturates at board edges; 1 = cursor wraps around
RW, $clog2(ROWS), cursor row width (derived; do not override)
CW, $clog2(COLS), cursor column width (derived; do not override)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
select  in  1  edit-mode request (level)
btn_up  in  1  cursor row - 1 (level, synchronous to clk)
btn_down  in  1  cursor row + 1
btn_left  in  1  cursor col - 1
btn_right  in  1  cursor col + 1
btn_center  in  1  commit edit at cursor
btn_clear  in  1  start full-board clear
mode  in  1  0 = row write, 1 = cell toggle
cell_inputs  in  COLS  row pattern; bit c maps to column c
input_board  in  ROWS*COLS  live board from engine
board_o  out  ROWS*COLS  edited board; cell (r,c) = bit r*COLS+c
cursor_row  out  RW  current cursor row
cursor_col  out  CW  current cursor column
busy  out  1  high while CLEAR sequence runs
editing  out  1  high in EDIT state

Behaviour:
- Reset (async): board_o=0, cursor_row=0, cursor_col=0, state=IDLE, busy=0, editing=0. All button and select history registers are cleared to 0.
- Edge detect:
  - Each button and select is registered every cycle, in every state.
  - An event is btn & ~btn_q: exactly one action per press, regardless of hold length.
  - If select is already high at reset release, it is seen as a rising edge on the first clock.
- States:
  - IDLE: board_o holds. On a select rising edge, go to LOAD.
  - LOAD (1 cycle): board_o <= input_board; cursor <= (0,0); then go to EDIT.
  - EDIT: editing=1. Process events as below. If select=0, go to IDLE; select low takes precedence over any same-cycle event, which is dropped.
  - CLEAR: busy=1. Zeroes row k on cycle k, for k = 0..ROWS-1 (ROWS cycles total). Then go to EDIT if select=1, else IDLE. All events are ignored during CLEAR, and select falling does not abort it. Cursor is unchanged.
- EDIT event priority (one action per cycle):
  1. clear: go to CLEAR, row counter = 0.
  2. center:
     - mode=0: board_o[row*COLS +: COLS] <= cell_inputs.
     - mode=1: board_o bit (row*COLS+col) is inverted.
  3. vertical move: up and down in the same cycle cancel (no move).
  4. horizontal move: left and right in the same cycle cancel.
  - Vertical and horizontal moves may both apply in the same cycle if no center or clear event is present.
  - A center event blocks moves in that cycle; those moves are lost, not queued.
- Bounds:
  - WRAP=0: up at row 0, down at row ROWS-1, left at col 0 and right at col COLS-1 are no-ops.
  - WRAP=1: these wrap to ROWS-1, 0, COLS-1 and 0 respectively.
  - For non-power-of-2 sizes, cursor values never exceed ROWS-1 / COLS-1.
- Latency: an edit, move or state change appears on the outputs at the same clock edge that first samples the button high (registered outputs, visible the following cycle).
- Reset mid-CLEAR or mid-EDIT: immediate return to reset values. No partial state survives.

Test Plan:
- Reset, select=1, input_board = 256'h1 -> after 2 edges: board_o = 256'h1, editing=1, cursor=(0,0).
- mode=0, cell_inputs=16'hA5A5, btn_down ×3 (separate presses), btn_center -> cursor_row=3 and board_o[63:48]=16'hA5A5. Then hold btn_center 10 cycles -> exactly one write.
- mode=1, cursor (2,5), btn_center twice -> bit 37 goes 0→1→0. btn_up+btn_down same cycle -> cursor_row unchanged.
- WRAP=0: btn_up at row 0 -> row stays 0. WRAP=1 (second instance): btn_up at row 0 -> row 15; btn_right at col 15 -> col 0.
- Board all ones, btn_clear -> busy=1 for exactly 16 cycles, board_o = 0 after; btn_center pulsed during CLEAR -> no effect; select dropped mid-CLEAR -> clear completes, then IDLE.
- Assert reset on the 5th cycle of CLEAR -> board_o=0, busy=0, state IDLE. select held high -> LOAD then EDIT re-entered.
